spi_xfer_sequencer: RTL and testbench
=====================================

// Module: spi_xfer_sequencer
// PURPOSE
//  Shares one CoreSPI master among NREQ requesters and sequences each byte transfer through
//  its APB slave port.
//  - Round-robin arbitration between requesters.
//  - Drives slave select, pushes TX bytes, pulls RX bytes, flags timeouts.
//  - Sits between the requesters and the CoreSPI APB port on PCLK.
// PARAMETERS
//  NREQ       2      number of requesters (1..8)
//  LENW       8      width of byte-count field
//  TIMEOUT    4096   PCLK cycles allowed per wait state before error abort
//  ADDR_SSEL  4'h4   CoreSPI slave-select register address
//  ADDR_DATA  4'h8   CoreSPI data register address (write = TX, read = RX)
// PORTS
//  PCLK           in   1          single clock, rising edge
//  PRESET         in   1          synchronous, active-high reset
//  req_i          in   NREQ       level request; hold until done_o/err_o while granted
//  req_ss_i       in   NREQ*8     per-requester slave-select mask (slice r = [8r+7:8r])
//  req_len_i      in   NREQ*LENW  per-requester byte count
//  req_tx_i       in   NREQ*8     per-requester next TX byte
//  grant_o        out  NREQ       one-hot grant, held for whole transaction
//  busy_o         out  1          transaction in progress
//  tx_pop_o       out  1          1-cycle pulse: granted requester's req_tx_i consumed this cycle
//  rx_data_o      out  8          received byte
//  rx_valid_o     out  1          1-cycle pulse qualifying rx_data_o
//  done_o         out  1          1-cycle pulse: transaction complete
//  err_o          out  1          1-cycle pulse: transaction aborted on timeout
//  PSEL/PENABLE/PWRITE  out 1 each   APB master controls to CoreSPI
//  PADDR          out  4          APB address
//  PWDATA         out  8          APB write data
//  PRDATA         in   8          APB read data
//  tx_reg_empty   in   1          CoreSPI TX holding register empty
//  rx_data_ready  in   1          CoreSPI RX byte available
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0, RR pointer = NREQ-1 (req 0 wins first).
//  Arbitration: in IDLE with any req_i set, grant goes to the first set requester after the
//   pointer (wrapping). grant_o registers next cycle and the pointer updates to the winner.
//   Arbitration is one grant per transaction, never per byte.
//  Latching: ss and len are latched at grant. Later changes to req_ss_i/req_len_i are ignored.
//  len = 0: done_o pulses 1 cycle after grant, with no APB activity.
//  APB: every access is 2 cycles, no wait states.
//   - SETUP: PSEL=1, PENABLE=0.
//   - ACCESS: PSEL=1, PENABLE=1. PRDATA is sampled at the end of ACCESS.
//   - Outside an access, PSEL, PENABLE, PWRITE, PADDR and PWDATA are all 0.
//  States:
//   IDLE   -> ARB on any req_i
//   ARB    -> SS_ON, or DONE if len=0
//   SS_ON  APB write ADDR_SSEL<=ss                            -> WT_TX
//   WT_TX  wait tx_reg_empty=1                                -> WR_TX
//   WR_TX  APB write ADDR_DATA<=req_tx_i[grant]; tx_pop_o pulses in SETUP (data sampled there)
//                                                             -> WT_RX
//   WT_RX  wait rx_data_ready=1                               -> RD_RX
//   RD_RX  APB read ADDR_DATA. rx_data_o<=PRDATA and rx_valid_o=1 the cycle after ACCESS.
//          count+1. If count==len -> SS_OFF, else -> WT_TX
//   SS_OFF APB write ADDR_SSEL<=8'h00                         -> DONE, or ERR if aborting
//   DONE   done_o=1, grant_o cleared                          -> IDLE
//   ERR    err_o=1, grant_o cleared                           -> IDLE
//  Timeout: the counter resets on entry to WT_TX/WT_RX. Reaching TIMEOUT sets the abort flag and
//   goes to SS_OFF, which ends in ERR. Bytes already delivered stand; no retry.
//  Byte count: LENW bits, compare for equality, never wraps past len.
//  Requests: req_i drop while granted is ignored until the transaction ends.
//  Back-to-back: the earliest next grant is 1 cycle after DONE/ERR (via IDLE).
//  busy_o is 1 from ARB through DONE/ERR inclusive.
//  Reset mid-transaction: next edge returns to IDLE with APB idle and grant cleared. CoreSPI
//   shares the same reset, so no SS_OFF write is issued.
// STRUCTURE
//  spi_seq_pkg: state enum, APB phase enum, default register address constants.
//  Sub-module spi_rr_arbiter:
//   - Parameterised NREQ; inputs req, pointer, enable.
//   - Output: one-hot winner (combinational).
//   - The pointer register lives in the parent.
//  Everything else (FSM, APB phase, counters, timeout) stays in spi_xfer_sequencer.
// TESTING
//  1 req0, ss=8'h04, len=2, tx A5,3C, PRDATA 11,22 -> APB writes SSEL=04, DATA=A5, DATA=3C,
//    SSEL=00 and 2 reads; rx_valid with 11 then 22; done_o once; 2 tx_pop_o pulses.
//  2 req0 and req1 both held continuously, len=1 each -> grants alternate 0,1,0,1;
//    grant_o never has two bits set.
//  3 len=0 on req1 -> done_o 1 cycle after grant; PSEL stays 0 throughout.
//  4 TIMEOUT=16, rx_data_ready held 0 -> after 16 WT_RX cycles, SSEL<=00 write then err_o;
//    no rx_valid_o; done_o never pulses.
//  5 PRESET asserted during WR_TX ACCESS -> next cycle all outputs 0, state IDLE;
//    the next request is served normally, starting with req 0.
//  6 tx_reg_empty delayed 5 cycles per byte, len=3 -> no DATA write before tx_reg_empty=1;
//    exactly 3 writes and 3 reads.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer: FSM states, APB phases
// and the default CoreSPI register addresses.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_SS_ON,
        ST_WT_TX,
        ST_WR_TX,
        ST_WT_RX,
        ST_RD_RX,
        ST_SS_OFF,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic {
        PH_SETUP,
        PH_ACCESS
    } phase_t;

    localparam logic [3:0] DEF_ADDR_SSEL = 4'h4;
    localparam logic [3:0] DEF_ADDR_DATA = 4'h8;

    // States that own a two-cycle APB access
    function automatic logic is_apb_state(state_t s);
        return (s == ST_SS_ON) || (s == ST_WR_TX) || (s == ST_RD_RX) || (s == ST_SS_OFF);
    endfunction

endpackage

// File: rtl/spi_seq_if.sv
// APB link between the sequencer and CoreSPI, including the two CoreSPI status flags.
interface spi_seq_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       tx_reg_empty;
    logic       rx_data_ready;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, tx_reg_empty, rx_data_ready
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, tx_reg_empty, rx_data_ready
    );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly after the pointer wins.
module spi_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    input  logic            enable,
    output logic [NREQ-1:0] winner
);

    logic found;

    // Walk outward from pointer+1; the first hit in that order wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (enable && !found && req[i] && (i == (int'(pointer) + off) % NREQ)) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Shares one CoreSPI master among NREQ requesters, sequencing slave select, TX pushes and
// RX pulls over the APB port with per-wait-state timeout abort.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int         NREQ      = 2,
    parameter int         LENW      = 8,
    parameter int         TIMEOUT   = 4096,
    parameter logic [3:0] ADDR_SSEL = DEF_ADDR_SSEL,
    parameter logic [3:0] ADDR_DATA = DEF_ADDR_DATA
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*8-1:0]  req_ss_i,
    input  logic [NREQ*LENW-1:0] req_len_i,
    input  logic [NREQ*8-1:0]  req_tx_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o,
    output logic               tx_pop_o,
    output logic [7:0]         rx_data_o,
    output logic               rx_valid_o,
    output logic               done_o,
    output logic               err_o,
    spi_seq_if.master          apb
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [NREQ-1:0]   grant_q, win;
    logic [PW-1:0]     ptr_q, win_idx;
    logic [7:0]        ss_q, ss_sel, tx_sel, tx_hold_q, rx_data_q;
    logic [LENW-1:0]   len_q, len_sel, cnt_q, cnt_inc;
    logic [TW-1:0]     timer_q;
    logic              abort_q, rx_valid_q, timeout, wait_stall;

    spi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (req_i),
        .pointer (ptr_q),
        .enable  (state_q == ST_IDLE),
        .winner  (win)
    );

    assign cnt_inc    = cnt_q + LENW'(1);
    assign timeout    = (timer_q == TW'(TIMEOUT - 1));
    assign wait_stall = ((state_q == ST_WT_TX) && !apb.tx_reg_empty) ||
                        ((state_q == ST_WT_RX) && !apb.rx_data_ready);

    // Slice selection: winner chooses ss/len to latch, the held grant chooses the live TX byte
    always_comb begin
        win_idx = '0;
        ss_sel  = '0;
        len_sel = '0;
        tx_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                ss_sel  = ss_sel | req_ss_i[8*i +: 8];
                len_sel = len_sel | req_len_i[LENW*i +: LENW];
            end
            if (grant_q[i]) begin
                tx_sel = tx_sel | req_tx_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SETUP;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // APB states advance only after their ACCESS cycle
    always_comb begin
        state_d = state_q;
        phase_d = (is_apb_state(state_q) && phase_q == PH_SETUP) ? PH_ACCESS : PH_SETUP;
        case (state_q)
            ST_IDLE:   if (|req_i) state_d = ST_ARB;
            ST_ARB:    state_d = (len_q == '0) ? ST_DONE : ST_SS_ON;
            ST_SS_ON:  if (phase_q == PH_ACCESS) state_d = ST_WT_TX;
            ST_WT_TX: begin
                if (apb.tx_reg_empty) state_d = ST_WR_TX;
                else if (timeout)     state_d = ST_SS_OFF;
            end
            ST_WR_TX:  if (phase_q == PH_ACCESS) state_d = ST_WT_RX;
            ST_WT_RX: begin
                if (apb.rx_data_ready) state_d = ST_RD_RX;
                else if (timeout)      state_d = ST_SS_OFF;
            end
            ST_RD_RX: begin
                if (phase_q == PH_ACCESS) state_d = (cnt_inc == len_q) ? ST_SS_OFF : ST_WT_TX;
            end
            ST_SS_OFF: if (phase_q == PH_ACCESS) state_d = abort_q ? ST_ERR : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            grant_q    <= '0;
            ptr_q      <= PW'(NREQ - 1);
            ss_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            tx_hold_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == ST_IDLE && |req_i) begin
                grant_q <= win;
                ptr_q   <= win_idx;
                ss_q    <= ss_sel;
                len_q   <= len_sel;
                cnt_q   <= '0;
                abort_q <= 1'b0;
            end
            if (state_q == ST_DONE || state_q == ST_ERR) begin
                grant_q <= '0;
            end
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (state_q == ST_WT_TX || state_q == ST_WT_RX) begin
                timer_q <= timer_q + TW'(1);
            end
            if (wait_stall && timeout) begin
                abort_q <= 1'b1;
            end
            if (state_q == ST_WR_TX && phase_q == PH_SETUP) begin
                tx_hold_q <= tx_sel;
            end
            if (state_q == ST_RD_RX && phase_q == PH_ACCESS) begin
                rx_data_q  <= apb.PRDATA;
                rx_valid_q <= 1'b1;
                cnt_q      <= cnt_inc;
            end
        end
    end

    // The TX byte is taken live in SETUP (the requester pops it there) and held for ACCESS
    always_comb begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        tx_pop_o    = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            ST_SS_ON: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (phase_q == PH_ACCESS);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = ADDR_SSEL;
                apb.PWDATA  = ss_q;
            end
            ST_WR_TX: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (phase_q == PH_ACCESS);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = ADDR_DATA;
                apb.PWDATA  = (phase_q == PH_SETUP) ? tx_sel : tx_hold_q;
                tx_pop_o    = (phase_q == PH_SETUP);
            end
            ST_RD_RX: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (phase_q == PH_ACCESS);
                apb.PADDR   = ADDR_DATA;
            end
            ST_SS_OFF: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (phase_q == PH_ACCESS);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = ADDR_SSEL;
            end
            ST_DONE: done_o = 1'b1;
            ST_ERR:  err_o  = 1'b1;
            default: ;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign grant_o    = grant_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a table of single transactions against a small
// CoreSPI/requester model, plus hand-written arbitration and mid-transaction reset sequences.
module tb_spi_xfer_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_i;
    logic [15:0] req_ss_i;
    logic [15:0] req_len_i;
    logic [15:0] req_tx_i;
    logic [1:0]  grant_o;
    logic        busy_o, tx_pop_o, rx_valid_o, done_o, err_o;
    logic [7:0]  rx_data_o;

    spi_seq_if bus ();

    spi_xfer_sequencer #(
        .NREQ(2), .LENW(8), .TIMEOUT(16), .ADDR_SSEL(4'h4), .ADDR_DATA(4'h8)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req_i      (req_i),
        .req_ss_i   (req_ss_i),
        .req_len_i  (req_len_i),
        .req_tx_i   (req_tx_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .tx_pop_o   (tx_pop_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .apb        (bus.master)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // CoreSPI and requester model state
    logic [7:0] tx_mem [2][64];
    logic [7:0] rd_mem [64];
    int tx_idx [2];
    int rd_idx = 0;
    int tx_cnt = 0, rx_cnt = 0;
    bit rx_pending = 1'b0;
    int txdly = 0, rxdly = 0;
    bit rxblock = 1'b0;

    assign req_tx_i          = {tx_mem[1][tx_idx[1]], tx_mem[0][tx_idx[0]]};
    assign bus.PRDATA        = rd_mem[rd_idx];
    assign bus.tx_reg_empty  = (tx_cnt == 0);
    assign bus.rx_data_ready = rx_pending && (rx_cnt == 0) && !rxblock;

    initial begin
        tx_idx[0] = 0;
        tx_idx[1] = 0;
    end

    wire data_wr = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR == 4'h8);
    wire data_rd = bus.PSEL && bus.PENABLE && !bus.PWRITE && (bus.PADDR == 4'h8);
    wire ss_wr   = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR == 4'h4) && (bus.PWDATA != 8'h00);

    always @(posedge PCLK) begin
        if (PRESET) begin
            tx_cnt     <= 0;
            rx_cnt     <= 0;
            rx_pending <= 1'b0;
        end else begin
            if (ss_wr || data_wr) tx_cnt <= txdly;
            else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
            if (data_wr) begin
                rx_pending <= 1'b1;
                rx_cnt     <= rxdly;
            end else if (data_rd) begin
                rx_pending <= 1'b0;
            end else if (rx_cnt != 0) begin
                rx_cnt <= rx_cnt - 1;
            end
            if (data_rd) rd_idx <= rd_idx + 1;
            if (tx_pop_o && grant_o[0]) tx_idx[0] <= tx_idx[0] + 1;
            if (tx_pop_o && grant_o[1]) tx_idx[1] <= tx_idx[1] + 1;
        end
    end

    // Monitor: logs APB accesses and output pulses, and counts protocol violations
    logic [12:0] log_q [$];
    logic [7:0]  rx_q [$];
    logic [1:0]  gnt_q [$];
    int cyc = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0;
    int grant_stamp = 0, end_stamp = 0;
    int viol_onehot = 0, viol_idle = 0, viol_phase = 0, viol_early = 0;
    logic [1:0] prev_grant = 2'b00;
    bit prev_setup = 1'b0;

    always @(negedge PCLK) begin
        cyc++;
        if (PRESET) begin
            prev_setup = 1'b0;
        end else begin
            if (bus.PSEL && bus.PENABLE)
                log_q.push_back({bus.PWRITE, bus.PADDR, bus.PWRITE ? bus.PWDATA : bus.PRDATA});
            if (tx_pop_o) pop_cnt++;
            if (rx_valid_o) rx_q.push_back(rx_data_o);
            if (done_o) begin done_cnt++; end_stamp = cyc; end
            if (err_o) begin err_cnt++; end_stamp = cyc; end
            if (grant_o != 2'b00 && prev_grant == 2'b00) begin
                gnt_q.push_back(grant_o);
                grant_stamp = cyc;
            end
            if ($countones(grant_o) > 1) viol_onehot++;
            if (!bus.PSEL && (bus.PENABLE || bus.PWRITE || bus.PADDR != 4'h0 || bus.PWDATA != 8'h00)) viol_idle++;
            if ((bus.PSEL && bus.PENABLE) != prev_setup) viol_phase++;
            if (bus.PSEL && !bus.PENABLE && bus.PWRITE && bus.PADDR == 4'h8 && !bus.tx_reg_empty) viol_early++;
            prev_setup = bus.PSEL && !bus.PENABLE;
        end
        prev_grant = grant_o;
    end

    typedef struct {
        logic [1:0]        req;
        logic [7:0]        ss;
        logic [7:0]        len;
        logic [3:0][7:0]   tx;
        logic [3:0][7:0]   rd;
        int                txdly;
        int                rxdly;
        bit                rxblock;
        logic [1:0]        exp_grant;
        int                exp_nlog;
        logic [7:0][12:0]  exp_log;
        int                exp_nrx;
        logic [3:0][7:0]   exp_rx;
        int                exp_pops;
        int                exp_done;
        int                exp_err;
        int                exp_lat;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t newVec();
        vec_t v;
        v.req = '0; v.ss = '0; v.len = '0; v.tx = '0; v.rd = '0;
        v.txdly = 0; v.rxdly = 0; v.rxblock = 1'b0;
        v.exp_grant = '0; v.exp_nlog = 0; v.exp_log = '0; v.exp_nrx = 0; v.exp_rx = '0;
        v.exp_pops = 0; v.exp_done = 0; v.exp_err = 0; v.exp_lat = -1;
        return v;
    endfunction

    function automatic logic [12:0] apbW(logic [3:0] a, logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [12:0] apbR(logic [7:0] d);
        return {1'b0, 4'h8, d};
    endfunction

    function automatic logic [31:0] allOutputs();
        return {1'b0, grant_o, busy_o, tx_pop_o, rx_valid_o, done_o, err_o,
                bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, rx_data_o};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int s_log = log_q.size();
        int s_rx  = rx_q.size();
        int s_g   = gnt_q.size();
        int s_pop = pop_cnt, s_done = done_cnt, s_err = err_cnt;
        int s_v1 = viol_onehot, s_v2 = viol_idle, s_v3 = viol_phase, s_v4 = viol_early;
        int n;
        logic [12:0] act_log;
        txdly   = v.txdly;
        rxdly   = v.rxdly;
        rxblock = v.rxblock;
        for (int k = 0; k < 4; k++) begin
            rd_mem[rd_idx + k]       = v.rd[k];
            tx_mem[0][tx_idx[0] + k] = v.tx[k];
            tx_mem[1][tx_idx[1] + k] = v.tx[k];
        end
        req_ss_i  = {v.ss, v.ss};
        req_len_i = {v.len, v.len};
        req_i     = v.req;
        n = 0;
        while (gnt_q.size() == s_g && n < 50) begin tick(); n++; end
        checkOutput($sformatf("v%0d_busy", idx), {31'd0, busy_o}, 32'd1);
        // Changing the request fields after grant must not affect this transaction
        req_i     = 2'b00;
        req_ss_i  = 16'hFFFF;
        req_len_i = 16'hFFFF;
        n = 0;
        while (done_cnt == s_done && err_cnt == s_err && n < 400) begin tick(); n++; end
        checkOutput($sformatf("v%0d_finished", idx), {31'd0, n < 400}, 32'd1);
        repeat (3) tick();
        checkOutput($sformatf("v%0d_grant", idx), (gnt_q.size() > s_g) ? 32'(gnt_q[s_g]) : 32'd0, 32'(v.exp_grant));
        checkOutput($sformatf("v%0d_nlog", idx), 32'(log_q.size() - s_log), 32'(v.exp_nlog));
        for (int k = 0; k < v.exp_nlog; k++) begin
            act_log = (s_log + k < log_q.size()) ? log_q[s_log + k] : 13'h1FFF;
            checkOutput($sformatf("v%0d_apb%0d", idx, k), 32'(act_log), 32'(v.exp_log[k]));
        end
        checkOutput($sformatf("v%0d_nrx", idx), 32'(rx_q.size() - s_rx), 32'(v.exp_nrx));
        for (int k = 0; k < v.exp_nrx; k++) begin
            checkOutput($sformatf("v%0d_rx%0d", idx, k),
                        (s_rx + k < rx_q.size()) ? 32'(rx_q[s_rx + k]) : 32'hFFFF, 32'(v.exp_rx[k]));
        end
        checkOutput($sformatf("v%0d_pops", idx), 32'(pop_cnt - s_pop), 32'(v.exp_pops));
        checkOutput($sformatf("v%0d_done", idx), 32'(done_cnt - s_done), 32'(v.exp_done));
        checkOutput($sformatf("v%0d_err", idx), 32'(err_cnt - s_err), 32'(v.exp_err));
        if (v.exp_lat >= 0)
            checkOutput($sformatf("v%0d_latency", idx), 32'(end_stamp - grant_stamp), 32'(v.exp_lat));
        checkOutput($sformatf("v%0d_onehot", idx), 32'(viol_onehot - s_v1), 32'd0);
        checkOutput($sformatf("v%0d_apb_idle", idx), 32'(viol_idle - s_v2), 32'd0);
        checkOutput($sformatf("v%0d_apb_phase", idx), 32'(viol_phase - s_v3), 32'd0);
        checkOutput($sformatf("v%0d_early_tx", idx), 32'(viol_early - s_v4), 32'd0);
    endtask

    logic [1:0] alt_exp [4];

    initial begin
        int n, s_g, s_done, s_err, s_v1, s_log;
        logic [12:0] act_log;

        // Basic two-byte transfer on requester 0
        vecs[0] = newVec();
        vecs[0].req = 2'b01; vecs[0].ss = 8'h04; vecs[0].len = 8'd2;
        vecs[0].tx[0] = 8'hA5; vecs[0].tx[1] = 8'h3C; vecs[0].rd[0] = 8'h11; vecs[0].rd[1] = 8'h22;
        vecs[0].exp_grant = 2'b01; vecs[0].exp_nlog = 6;
        vecs[0].exp_log[0] = apbW(4'h4, 8'h04); vecs[0].exp_log[1] = apbW(4'h8, 8'hA5);
        vecs[0].exp_log[2] = apbR(8'h11);       vecs[0].exp_log[3] = apbW(4'h8, 8'h3C);
        vecs[0].exp_log[4] = apbR(8'h22);       vecs[0].exp_log[5] = apbW(4'h4, 8'h00);
        vecs[0].exp_nrx = 2; vecs[0].exp_rx[0] = 8'h11; vecs[0].exp_rx[1] = 8'h22;
        vecs[0].exp_pops = 2; vecs[0].exp_done = 1; vecs[0].exp_lat = 17;

        // Zero-length transfer on requester 1
        vecs[1] = newVec();
        vecs[1].req = 2'b10; vecs[1].ss = 8'h55; vecs[1].len = 8'd0;
        vecs[1].exp_grant = 2'b10; vecs[1].exp_done = 1; vecs[1].exp_lat = 1;

        // Three bytes with tx_reg_empty delayed 5 cycles per byte
        vecs[2] = newVec();
        vecs[2].req = 2'b01; vecs[2].ss = 8'h81; vecs[2].len = 8'd3; vecs[2].txdly = 5;
        vecs[2].tx[0] = 8'h01; vecs[2].tx[1] = 8'h02; vecs[2].tx[2] = 8'h03;
        vecs[2].rd[0] = 8'h0A; vecs[2].rd[1] = 8'h0B; vecs[2].rd[2] = 8'h0C;
        vecs[2].exp_grant = 2'b01; vecs[2].exp_nlog = 8;
        vecs[2].exp_log[0] = apbW(4'h4, 8'h81); vecs[2].exp_log[1] = apbW(4'h8, 8'h01);
        vecs[2].exp_log[2] = apbR(8'h0A);       vecs[2].exp_log[3] = apbW(4'h8, 8'h02);
        vecs[2].exp_log[4] = apbR(8'h0B);       vecs[2].exp_log[5] = apbW(4'h8, 8'h03);
        vecs[2].exp_log[6] = apbR(8'h0C);       vecs[2].exp_log[7] = apbW(4'h4, 8'h00);
        vecs[2].exp_nrx = 3; vecs[2].exp_rx[0] = 8'h0A; vecs[2].exp_rx[1] = 8'h0B; vecs[2].exp_rx[2] = 8'h0C;
        vecs[2].exp_pops = 3; vecs[2].exp_done = 1;

        // RX never ready: 16 WT_RX cycles, deselect, then err
        vecs[3] = newVec();
        vecs[3].req = 2'b10; vecs[3].ss = 8'h02; vecs[3].len = 8'd2; vecs[3].rxblock = 1'b1;
        vecs[3].tx[0] = 8'h77;
        vecs[3].exp_grant = 2'b10; vecs[3].exp_nlog = 3;
        vecs[3].exp_log[0] = apbW(4'h4, 8'h02); vecs[3].exp_log[1] = apbW(4'h8, 8'h77);
        vecs[3].exp_log[2] = apbW(4'h4, 8'h00);
        vecs[3].exp_pops = 1; vecs[3].exp_err = 1; vecs[3].exp_lat = 24;

        for (int i = 0; i < 64; i++) begin
            rd_mem[i] = 8'h00; tx_mem[0][i] = 8'h00; tx_mem[1][i] = 8'h00;
        end
        PRESET = 1'b1; req_i = 2'b00; req_ss_i = '0; req_len_i = '0;
        repeat (2) tick();
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        PRESET = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) applyStimulus(i, vecs[i]);

        // Both requesters held: grants must alternate starting at 0
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
        txdly = 0; rxdly = 2; rxblock = 1'b0;
        s_g = gnt_q.size(); s_done = done_cnt; s_err = err_cnt; s_v1 = viol_onehot;
        req_ss_i = {8'h20, 8'h10}; req_len_i = {8'd1, 8'd1}; req_i = 2'b11;
        n = 0;
        while (done_cnt - s_done < 4 && n < 400) begin tick(); n++; end
        req_i = 2'b00;
        repeat (3) tick();
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("alt_grant%0d", k), (gnt_q.size() > s_g + k) ? 32'(gnt_q[s_g + k]) : 32'd0, 32'(alt_exp[k]));
        checkOutput("alt_done", 32'(done_cnt - s_done), 32'd4);
        checkOutput("alt_err", 32'(err_cnt - s_err), 32'd0);
        checkOutput("alt_onehot", 32'(viol_onehot - s_v1), 32'd0);

        // Reset during the WR_TX access, then requester 0 must win again
        req_len_i = {8'd1, 8'd2}; req_i = 2'b01;
        n = 0;
        while (!(data_wr) && n < 100) begin tick(); n++; end
        checkOutput("rst_reached_wr_tx", {31'd0, n < 100}, 32'd1);
        s_log = log_q.size();
        PRESET = 1'b1; req_i = 2'b00;
        tick();
        checkOutput("rst_mid_outputs", allOutputs(), 32'd0);
        PRESET = 1'b0;
        repeat (2) tick();
        s_g = gnt_q.size(); s_done = done_cnt;
        req_len_i = {8'd1, 8'd1}; req_i = 2'b11;
        n = 0;
        while (gnt_q.size() == s_g && n < 50) begin tick(); n++; end
        req_i = 2'b00;
        checkOutput("rst_next_grant", (gnt_q.size() > s_g) ? 32'(gnt_q[s_g]) : 32'd0, 32'b01);
        n = 0;
        while (done_cnt == s_done && n < 200) begin tick(); n++; end
        checkOutput("rst_next_done", 32'(done_cnt - s_done), 32'd1);
        act_log = (log_q.size() > s_log) ? log_q[s_log] : 13'h1FFF;
        checkOutput("rst_next_first_apb", 32'(act_log), 32'(apbW(4'h4, 8'h10)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
